// File: rtl/accum_tile_ctrl.sv
// Accumulator write-path and output-drain sequencer for one systolic output tile group.
// Streams num_row row writes per K-tile, clears the skew pipeline, then hands off to the output controller.
module accum_tile_ctrl #(
    parameter int SYS_COL    = 4,
    parameter int ACCUM_SIZE = 16,
    parameter int DRAIN_CYC  = 7,
    localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL,
    localparam int ADDR_WIDTH = ($clog2(ACCUM_ROW) > 0) ? $clog2(ACCUM_ROW) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [15:0]           num_row,
    input  logic [7:0]            num_tile,
    input  logic [7:0]            out_base_addr,
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic                  wr_en_ctrl,
    output logic [ADDR_WIDTH-1:0] wr_addr_ctrl,
    output logic                  accum_mode,
    output logic                  accum_rstn,
    output logic                  out_en,
    output logic [7:0]            out_base,
    output logic [15:0]           out_num_row,
    input  logic                  out_done,
    output logic [7:0]            tile_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int DCW = ($clog2(DRAIN_CYC) > 0) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(DRAIN_CYC - 1);
    localparam logic [15:0]    ACCUM_ROW_W = 16'(ACCUM_ROW);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TILE,
        WRITE,
        DRAIN,
        CLEAR,
        OUT_START,
        OUT_WAIT,
        DONE
    } state_t;

    state_t         state;
    logic [15:0]    num_row_l;
    logic [7:0]     num_tile_l;
    logic [DCW-1:0] drain_cnt;

    logic [15:0]    num_row_clamp;
    logic           last_row;
    logic           more_tiles;

    always_comb begin
        num_row_clamp = (num_row > ACCUM_ROW_W) ? ACCUM_ROW_W : num_row;
        last_row      = (16'(wr_addr_ctrl) == (num_row_l - 16'd1));
        more_tiles    = (({1'b0, tile_idx} + 9'd1) < {1'b0, num_tile_l});
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            num_row_l    <= '0;
            num_tile_l   <= '0;
            drain_cnt    <= '0;
            tile_ready   <= 1'b0;
            wr_en_ctrl   <= 1'b0;
            wr_addr_ctrl <= '0;
            accum_mode   <= 1'b0;
            accum_rstn   <= 1'b1;
            out_en       <= 1'b0;
            out_base     <= '0;
            out_num_row  <= '0;
            tile_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_row_l   <= num_row_clamp;
                        num_tile_l  <= num_tile;
                        out_base    <= out_base_addr;
                        out_num_row <= num_row_clamp;
                        tile_idx    <= '0;
                        accum_mode  <= 1'b0;
                        busy        <= 1'b1;
                        // Empty work skips straight to completion without touching the accumulator.
                        if (num_row_clamp == 16'd0 || num_tile == 8'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            tile_ready <= 1'b1;
                            state      <= WAIT_TILE;
                        end
                    end
                end
                WAIT_TILE: begin
                    if (tile_valid) begin
                        tile_ready   <= 1'b0;
                        wr_en_ctrl   <= 1'b1;
                        wr_addr_ctrl <= '0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_row) begin
                        wr_en_ctrl   <= 1'b0;
                        wr_addr_ctrl <= '0;
                        drain_cnt    <= '0;
                        state        <= DRAIN;
                    end else begin
                        wr_addr_ctrl <= wr_addr_ctrl + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        accum_rstn <= 1'b0;
                        state      <= CLEAR;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    accum_rstn <= 1'b1;
                    if (more_tiles) begin
                        tile_idx   <= tile_idx + 8'd1;
                        accum_mode <= 1'b1;
                        tile_ready <= 1'b1;
                        state      <= WAIT_TILE;
                    end else begin
                        out_en <= 1'b1;
                        state  <= OUT_START;
                    end
                end
                OUT_START: begin
                    out_en <= 1'b0;
                    state  <= OUT_WAIT;
                end
                OUT_WAIT: begin
                    if (out_done) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    accum_mode <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/accum_tile_ctrl.md
Name: accum_tile_ctrl

Overview:
Sequencer for the accumulator write path and output drain of one systolic-array output tile group. For each of num_tile K-tiles it:
- drives the accumulator write controller's row enable and address for num_row rows;
- waits out the column skew, then pulses the write controller's clear.
The first tile overwrites the accumulator; later tiles accumulate. After the last tile it starts the output controller (ReLU to output memory) and reports completion.

Parameters:
SYS_COL, 4, systolic array columns (accumulator banks)
ACCUM_SIZE, 16, total accumulator entries
ACCUM_ROW, ACCUM_SIZE/SYS_COL (localparam), rows per bank
ADDR_WIDTH, $clog2(ACCUM_ROW) (localparam), accumulator row address width
DRAIN_CYC, 7, idle cycles after the last row write so skewed columns land

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
num_row  in  16  rows per tile; latched at start
num_tile  in  8  K-tiles to accumulate; latched at start
out_base_addr  in  8  output memory base; latched at start
tile_valid  in  1  upstream array has a tile ready to stream
tile_ready  out  1  controller waiting for a tile
wr_en_ctrl  out  1  row write enable to accumulator write controller
wr_addr_ctrl  out  ADDR_WIDTH  row address to accumulator write controller
accum_mode  out  1  0 = overwrite (first tile), 1 = accumulate
accum_rstn  out  1  active-low clear pulse to write controller skew pipeline
out_en  out  1  one-cycle start to output controller
out_base  out  8  base address to output controller
out_num_row  out  16  row count to output controller
out_done  in  1  output controller finished
tile_idx  out  8  index of current tile
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. Reset values:
  - wr_en_ctrl=0, wr_addr_ctrl=0, accum_mode=0, accum_rstn=1, out_en=0;
  - out_base=0, out_num_row=0, tile_idx=0;
  - tile_ready=0, busy=0, done=0;
  - state=IDLE.
- Reset asserted mid-operation: returns to IDLE on the next edge and abandons the tile without a clear pulse. Latched config is discarded.
- Latching at start:
  - num_row latched as min(num_row, ACCUM_ROW);
  - if latched num_row==0 or num_tile==0: go directly to DONE (done pulses at T+1), no writes, no out_en.
- start outside IDLE is ignored.
- States: IDLE -> WAIT_TILE -> WRITE -> DRAIN -> CLEAR -> (WAIT_TILE | OUT_START) -> OUT_WAIT -> DONE -> IDLE.
- Cycle T, start sampled in IDLE: at T+1 state=WAIT_TILE, tile_ready=1, tile_idx=0, accum_mode=0.
- WAIT_TILE: tile_ready=1. tile_valid sampled high at cycle U gives:
  - cycles U+1 .. U+num_row: wr_en_ctrl=1, wr_addr_ctrl=0,1,..,num_row-1, with no gaps;
  - tile_ready=0 from U+1.
  - tile_valid is ignored in all other states.
- DRAIN: exactly DRAIN_CYC cycles with wr_en_ctrl=0 and wr_addr_ctrl=0.
- CLEAR: one cycle with accum_rstn=0. On exit:
  - tile_idx+1 < num_tile: tile_idx increments, accum_mode=1, go to WAIT_TILE;
  - otherwise: go to OUT_START.
- OUT_START: one cycle with out_en=1. out_base and out_num_row are held from the latched values until the next start.
- OUT_WAIT: wait for out_done. out_done seen in any other state is ignored. out_done in the same cycle as out_en is not counted.
- DONE: done=1 for one cycle, then IDLE; busy drops with the IDLE entry.
- accum_mode holds its value through WRITE and DRAIN of each tile and returns to 0 in IDLE.
- tile_idx counter: 8 bits, never wraps (bounded by num_tile ≤ 255).

Test Plan:
1. Single tile (rstn low 1 cycle, start with num_row=4, num_tile=1, base=0; tile_valid high at U):
   - wr_en_ctrl high U+1..U+4 with addr 0,1,2,3, accum_mode=0;
   - 7 idle cycles, then accum_rstn low at U+12, out_en at U+13;
   - out_done at U+20 gives done at U+21.
2. Two tiles (num_tile=2, num_row=4):
   - second WRITE burst has accum_mode=1 and tile_idx=1;
   - exactly two accum_rstn pulses and one out_en.
3. Clamp (num_row=9 with ACCUM_ROW=4): only addresses 0..3 written; out_num_row=4.
4. Degenerate config:
   - num_tile=0: done one cycle after start, no wr_en_ctrl and no out_en;
   - num_row=0: same.
5. Back-pressure and spurious inputs:
   - tile_valid withheld for 20 cycles: tile_ready stays 1 and wr_en_ctrl stays 0 throughout;
   - start and out_done pulsed during WRITE: no effect.
6. Reset mid-operation: rstn low during WRITE at addr 2 gives all outputs at reset values next cycle; a new start then runs cleanly from addr 0.
